// File: rtl/fetch_decode_fifo_pkg.sv
// Shared fetch/decode configuration: pipeline widths, queue depth and the
// entry format that travels from fetch to decode.
package fetch_decode_fifo_pkg;

    localparam int FETCH_WIDTH             = 4;
    localparam int DECODE_WIDTH            = 2;
    localparam int FETCH_DECODE_FIFO_DEPTH = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_decode_pack_t;

endpackage

// File: rtl/fetch_decode_fifo.sv
// Multi-port in-order instruction queue between fetch and decode: up to
// IN_WIDTH writes and OUT_WIDTH prefix-retires per cycle, cleared by flush.
module fetch_decode_fifo
    import fetch_decode_fifo_pkg::*;
#(
    parameter int DEPTH     = FETCH_DECODE_FIFO_DEPTH,
    parameter int IN_WIDTH  = FETCH_WIDTH,
    parameter int OUT_WIDTH = DECODE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [IN_WIDTH-1:0]      data_in_enable,
    input  fetch_decode_pack_t       data_in [0:IN_WIDTH-1],
    input  logic [IN_WIDTH-1:0]      data_in_valid,
    input  logic                     push,
    input  logic                     flush,
    output fetch_decode_pack_t       data_out [0:OUT_WIDTH-1],
    output logic [OUT_WIDTH-1:0]     data_out_valid,
    input  logic [OUT_WIDTH-1:0]     pop,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Port widths are assumed to be at most 32 bits wide.
    function automatic logic [CW-1:0] popcount(input logic [31:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    fetch_decode_pack_t storage [DEPTH];
    logic [PW-1:0]      rptr;
    logic [PW-1:0]      wptr;
    logic [CW-1:0]      free;
    logic [CW-1:0]      nw;
    logic [CW-1:0]      nr;
    logic [IN_WIDTH-1:0] wr_mask;

    // Enables and valids come from the registered count only: no bypass paths.
    always_comb begin
        free = CW'(DEPTH) - count;
        for (int i = 0; i < IN_WIDTH; i++) begin
            data_in_enable[i] = (free > CW'(i));
        end
        for (int i = 0; i < OUT_WIDTH; i++) begin
            data_out_valid[i] = (count > CW'(i));
            data_out[i]       = storage[rptr + PW'(i)];
        end
    end

    assign wr_mask = push ? (data_in_valid & data_in_enable) : '0;
    assign nw      = popcount(32'(wr_mask));
    assign nr      = popcount(32'(pop & data_out_valid));

    // NOTE: the storage array is deliberately left out of reset; only the
    // pointers and count define which entries are meaningful.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (!flush && wr_mask[i]) begin
                storage[wptr + PW'(i)] <= data_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            rptr  <= rptr + PW'(nr);
            wptr  <= wptr + PW'(nw);
            count <= count - nr + nw;
        end
    end

    logic [IN_WIDTH-1:0]  valid_inc;
    logic [OUT_WIDTH-1:0] pop_inc;
    assign valid_inc = data_in_valid + IN_WIDTH'(1);
    assign pop_inc   = pop + OUT_WIDTH'(1);

    // A contiguous prefix from bit 0 has no set bit above a clear bit.
    a_valid_prefix: assert property (@(posedge clk) disable iff (!rst)
        push |-> ((data_in_valid & valid_inc) == '0));
    a_pop_prefix: assert property (@(posedge clk) disable iff (!rst)
        ((pop & pop_inc) == '0));

endmodule

// File: tb/tb_fetch_decode_fifo.sv
// Self-checking bench for fetch_decode_fifo: a queue model tracks accepted
// entries and a negedge compare process checks every DUT output against it.
module tb_fetch_decode_fifo;
    import fetch_decode_fifo_pkg::*;

    localparam int DEPTH = 16;
    localparam int IN_W  = 4;
    localparam int OUT_W = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [IN_W-1:0]    din_en;
    fetch_decode_pack_t din [0:IN_W-1];
    logic [IN_W-1:0]    din_valid;
    logic               push;
    logic               flush;
    fetch_decode_pack_t dout [0:OUT_W-1];
    logic [OUT_W-1:0]   dout_valid;
    logic [OUT_W-1:0]   pop;
    logic [4:0]         count;

    int passed = 0;
    int total  = 0;
    bit cmp_on = 1'b0;

    fetch_decode_pack_t model_q [$];
    logic [31:0]        next_pc;

    always #5 clk = ~clk;

    fetch_decode_fifo #(.DEPTH(DEPTH), .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in_enable (din_en),
        .data_in        (din),
        .data_in_valid  (din_valid),
        .push           (push),
        .flush          (flush),
        .data_out       (dout),
        .data_out_valid (dout_valid),
        .pop            (pop),
        .count          (count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic fetch_decode_pack_t mk(input logic [31:0] pc);
        fetch_decode_pack_t e;
        e.pc    = pc;
        e.instr = pc ^ 32'h00C0_FFEE;
        return e;
    endfunction

    // One clock: drive inputs, take the edge, then advance the model.
    task automatic step(input logic p, input logic [IN_W-1:0] v,
                        input logic [OUT_W-1:0] pp, input logic f);
        int free;
        int nr;
        int acc;
        fetch_decode_pack_t offered [IN_W];
        push = p; din_valid = v; pop = pp; flush = f;
        for (int i = 0; i < IN_W; i++) begin
            din[i]     = mk(next_pc + 32'(4 * i));
            offered[i] = din[i];
        end
        @(posedge clk);
        if (rst) begin
            free = DEPTH - model_q.size();
            if (f) begin
                model_q.delete();
            end else begin
                nr = 0;
                for (int i = 0; i < OUT_W; i++)
                    if (pp[i] && i < model_q.size()) nr++;
                repeat (nr) void'(model_q.pop_front());
                acc = 0;
                for (int i = 0; i < IN_W; i++) begin
                    if (p && v[i] && i < free) begin
                        model_q.push_back(offered[i]);
                        acc++;
                    end
                end
                next_pc = next_pc + 32'(4 * acc);
            end
        end
        #1;
        push = 1'b0; din_valid = '0; pop = '0; flush = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [IN_W-1:0]  exp_en;
        logic [OUT_W-1:0] exp_ov;
        if (cmp_on) begin
            for (int i = 0; i < IN_W; i++)  exp_en[i] = (DEPTH - model_q.size()) > i;
            for (int i = 0; i < OUT_W; i++) exp_ov[i] = model_q.size() > i;
            check("cmp_count", 32'(count), 32'(model_q.size()));
            check("cmp_in_enable", 32'(din_en), 32'(exp_en));
            check("cmp_out_valid", 32'(dout_valid), 32'(exp_ov));
            for (int i = 0; i < OUT_W; i++) begin
                if (i < model_q.size()) begin
                    check("cmp_out_pc", dout[i].pc, model_q[i].pc);
                    check("cmp_out_instr", dout[i].instr, model_q[i].instr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        push = 1'b0; flush = 1'b0; pop = '0; din_valid = '0;
        for (int i = 0; i < IN_W; i++) din[i] = mk(32'h0);
        next_pc = 32'h8000_0000;

        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        cmp_on = 1'b1;
        check("reset_enable", 32'(din_en), 32'h0000_000F);
        check("reset_valid", 32'(dout_valid), 32'h0);
        check("reset_count", 32'(count), 32'h0);

        step(1'b1, 4'b1111, 2'b00, 1'b0);
        check("first_push_count", 32'(count), 32'd4);
        check("first_push_valid", 32'(dout_valid), 32'h3);
        check("first_push_pc0", dout[0].pc, 32'h8000_0000);

        repeat (3) step(1'b1, 4'b1111, 2'b00, 1'b0);
        check("full_count", 32'(count), 32'd16);
        check("full_enable", 32'(din_en), 32'h0);

        step(1'b1, 4'b1111, 2'b00, 1'b0);
        check("push_when_full_count", 32'(count), 32'd16);
        check("push_when_full_pc0", dout[0].pc, 32'h8000_0000);
        check("push_when_full_pc1", dout[1].pc, 32'h8000_0004);

        step(1'b0, 4'b0000, 2'b11, 1'b0);
        check("near_full_count", 32'(count), 32'd14);
        check("near_full_enable", 32'(din_en), 32'h3);
        check("near_full_pc0", dout[0].pc, 32'h8000_0008);
        step(1'b1, 4'b1111, 2'b00, 1'b0);
        check("near_full_push_count", 32'(count), 32'd16);

        repeat (4) step(1'b0, 4'b0000, 2'b11, 1'b0);
        check("pre_flush_count", 32'(count), 32'd8);
        step(1'b1, 4'b1111, 2'b01, 1'b1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(dout_valid), 32'h0);
        check("flush_enable", 32'(din_en), 32'h0000_000F);

        repeat (4) step(1'b1, 4'b1111, 2'b00, 1'b0);
        repeat (7) step(1'b0, 4'b0000, 2'b11, 1'b0);
        check("pre_wrap_count", 32'(count), 32'd2);
        check("pre_wrap_pc0", dout[0].pc, 32'h8000_0080);
        step(1'b1, 4'b0001, 2'b00, 1'b0);
        check("pre_wrap_count3", 32'(count), 32'd3);
        step(1'b1, 4'b0111, 2'b11, 1'b0);
        check("wrap_count", 32'(count), 32'd4);
        check("wrap_pc0", dout[0].pc, 32'h8000_0088);
        check("wrap_pc1", dout[1].pc, 32'h8000_008C);

        step(1'b1, 4'b0001, 2'b00, 1'b0);
        check("pre_reset_count", 32'(count), 32'd5);
        #2 rst = 1'b0;
        model_q.delete();
        #1;
        check("async_reset_valid", 32'(dout_valid), 32'h0);
        check("async_reset_count", 32'(count), 32'h0);
        check("async_reset_enable", 32'(din_en), 32'h0000_000F);
        @(posedge clk);
        #2 rst = 1'b1;

        step(1'b1, 4'b0011, 2'b00, 1'b0);
        step(1'b1, 4'b1111, 2'b01, 1'b0);
        step(1'b0, 4'b0000, 2'b11, 1'b0);
        repeat (3) step(1'b0, 4'b0000, 2'b11, 1'b0);
        check("drain_count", 32'(count), 32'd0);

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_decode_fifo.md
# fetch_decode_fifo

Multi-port instruction queue between the fetch stage and the decode stage. Accepts up to FETCH_WIDTH fetch_decode_pack_t entries per cycle from fetch and presents the oldest DECODE_WIDTH entries to decode, which may retire any in-order prefix of them. It tells fetch how many slots are free through a thermometer-coded enable vector, and it clears completely on a pipeline flush.

## Interface
- DEPTH, `FETCH_DECODE_FIFO_DEPTH` (16): number of entries; must be a power of two and at least FETCH_WIDTH.
- IN_WIDTH, `FETCH_WIDTH`: number of write ports.
- OUT_WIDTH, `DECODE_WIDTH`: number of read ports.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- data_in_enable  out  IN_WIDTH  thermometer code; bit i = 1 when free entries ≥ i+1.
- data_in  in  fetch_decode_pack_t[0:IN_WIDTH-1]  entries to write, slot 0 oldest.
- data_in_valid  in  IN_WIDTH  per-slot valid; contiguous prefix from bit 0.
- push  in  1  write qualifier.
- flush  in  1  discard all contents.
- data_out  out  fetch_decode_pack_t[0:OUT_WIDTH-1]  oldest entries, slot 0 oldest.
- data_out_valid  out  OUT_WIDTH  bit i = 1 when count ≥ i+1.
- pop  in  OUT_WIDTH  decode consumes the slots that are set; contiguous prefix.
- count  out  $clog2(DEPTH)+1  current occupancy, for performance counters.

## Operation
- State: storage array[DEPTH], rptr and wptr ($clog2(DEPTH) bits each, wrap modulo DEPTH), and count ($clog2(DEPTH)+1 bits).
- Reset values: rptr = wptr = count = 0. data_out_valid = 0. data_in_enable = all ones. Storage contents are don't-care.
- Write count nw = popcount(data_in_valid & data_in_enable) when push = 1, else 0. Slot i goes to storage[(wptr+i) mod DEPTH]. wptr += nw.
- Valid bits above data_in_enable are dropped silently. Fetch is responsible for never sending them.
- Read count nr = popcount(pop & data_out_valid). rptr += nr. Pop bits above data_out_valid are ignored.
- count_next = count − nr + nw.
  - Overflow cannot occur, because data_in_enable is derived from the pre-pop count.
  - Underflow cannot occur, because pops are masked by data_out_valid.
- Outputs:
  - data_out[i] = storage[(rptr+i) mod DEPTH].
  - data_out_valid and data_in_enable are purely combinational from the registered count.
  - There is no push→pop bypass and no pop→enable bypass.
- Flush: at the edge, rptr = wptr = count = 0. It overrides push and pop in the same cycle, and the written data is discarded.
- Non-contiguous data_in_valid or pop triggers a simulation assertion. RTL behaviour in that case is per the popcount rules above.

## Timing
- Write latency 1: an entry pushed at edge N appears on data_out from edge N onward (next cycle) if it is among the oldest OUT_WIDTH entries.
- Pop takes effect at the edge. data_out shifts to the next entries in the following cycle.
- Full (count = DEPTH): data_in_enable = 0, and push is a no-op.
- Empty: data_out_valid = 0, and pop is a no-op.
- Simultaneous push and pop when full: the pop is honoured, the push writes nothing because enable = 0, and count drops by nr.
- Pointer wrap: writes and reads spanning the DEPTH−1 → 0 boundary stay in order.
- Reset asserted mid-operation clears state immediately, without waiting for clk. Outputs take their reset values within the same cycle.

## Structure
- fetch_decode_pack_t, `FETCH_WIDTH`, `DECODE_WIDTH` and the new `FETCH_DECODE_FIFO_DEPTH` live in the shared config/common package.
- No sub-module: a single module with a local popcount function and a flat register array.

## Test plan
Bench configuration: DEPTH = 16, IN = 4, OUT = 2.
- Reset and idle:
  - Release rst with no push → data_in_enable = 4'b1111, data_out_valid = 0, count = 0.
  - Push 4 valid PCs 0x80000000..0x8000000C → next cycle count = 4, data_out_valid = 2'b11, data_out[0].pc = 0x80000000.
- Fill to full:
  - Push 4 per cycle for 4 cycles with no pop → count = 16, data_in_enable = 0.
  - A further push leaves count = 16 and the contents unchanged.
- Near full: with count = 14, data_in_enable = 4'b0011. Push data_in_valid = 4'b1111 → only 2 written, count = 16.
- Concurrent push and pop, including wrap:
  - With count = 3 and rptr = 14, pop = 2'b11 and push 3 → count = 4, rptr = 0.
  - The following data_out entries continue in PC order across the wrap.
- Flush priority and async reset:
  - Flush with push = 1 and pop = 2'b01 at count = 8 → next cycle count = 0, data_out_valid = 0, data_in_enable = 4'b1111.
  - Drop rst asynchronously mid-cycle at count = 5 → data_out_valid = 0 immediately.
